val_rdy_skid_buf: RTL
=====================

VAL_RDY_SKID_BUF -- requirements
Module: val_rdy_skid_buf

Interface
REQ-001 The block SHALL have parameter p_nbits, default 32: width of the message carried through the buffer.
REQ-002 The block SHALL have port clk, input, 1 bit: clock; all state updates on posedge clk.
REQ-003 The block SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-004 The block SHALL have port enq_val, input, 1 bit: upstream message valid.
REQ-005 The block SHALL have port enq_rdy, output, 1 bit: buffer can accept a message this cycle.
REQ-006 The block SHALL have port enq_msg, input, p_nbits: upstream message.
REQ-007 The block SHALL have port deq_val, output, 1 bit: buffer presents a valid message.
REQ-008 The block SHALL have port deq_rdy, input, 1 bit: downstream can accept a message.
REQ-009 The block SHALL have port deq_msg, output, p_nbits: head message.
REQ-010 The block SHALL have port num_entries, output, 2 bits: current occupancy, 0..2.

Function
REQ-011 The block SHALL be a 2-entry FIFO with entries main (head) and skid (second), built from the team's enable registers.
REQ-012 An enqueue SHALL occur on a posedge where enq_val && enq_rdy; a dequeue SHALL occur where deq_val && deq_rdy.
REQ-013 The FSM SHALL have states EMPTY (0 entries), HALF (1 entry), FULL (2 entries); num_entries SHALL equal 0/1/2 respectively.
REQ-014 enq_rdy SHALL equal (state != FULL) and SHALL NOT depend combinationally on deq_rdy or any input.
REQ-015 deq_val SHALL equal (state != EMPTY) and SHALL NOT depend combinationally on enq_val; deq_msg SHALL equal main.
REQ-016 EMPTY: enqueue -> HALF, main <= enq_msg; otherwise stay EMPTY.
REQ-017 HALF: enqueue and no dequeue -> FULL, skid <= enq_msg.
REQ-018 HALF: dequeue and no enqueue -> EMPTY.
REQ-019 HALF: simultaneous enqueue and dequeue -> HALF, main <= enq_msg.
REQ-020 HALF: neither event -> stay HALF, main unchanged.
REQ-021 FULL: dequeue -> HALF, main <= skid; no enqueue is possible because enq_rdy=0; no dequeue -> stay FULL.
REQ-022 Latency SHALL be 1 cycle: a message enqueued on edge N SHALL appear on deq_msg with deq_val=1 in the cycle after edge N.
REQ-023 With deq_rdy held high, throughput SHALL be one message per cycle indefinitely.
REQ-024 Messages SHALL leave in enqueue order; none SHALL be dropped or duplicated.
REQ-025 While deq_val=1 and deq_rdy=0, deq_msg SHALL hold stable.
REQ-026 enq_val asserted while enq_rdy=0 SHALL be ignored, with no state or data change.
REQ-027 main and skid SHALL NOT be reset; their contents are don't-care while not occupied.
REQ-028 Under `ifndef SYNTHESIS the block SHALL assert that enq_val and deq_rdy are not X when reset=0.

Reset
REQ-029 While reset=1 at a posedge, state SHALL become EMPTY regardless of enq_val and deq_rdy.
REQ-030 After reset, the outputs SHALL be enq_rdy=1, deq_val=0, and num_entries=0.
REQ-031 Reset mid-operation, in HALF or FULL, SHALL discard all held messages; no stale message SHALL appear after reset.
REQ-032 During the reset cycle, enq_val SHALL NOT cause an enqueue.

Verification
REQ-033 The bench SHALL cover pass-through (p_nbits=8): deq_rdy=1 throughout, enqueue 0x11, 0x22, 0x33 on consecutive cycles -> deq_msg 0x11, 0x22, 0x33 on the next three cycles, num_entries stays 1, and enq_rdy stays 1.
REQ-034 The bench SHALL cover fill and backpressure: deq_rdy=0, enqueue 0xA1 then 0xB2 -> num_entries=2 and enq_rdy=0; enq_val with 0xC3 for 3 cycles -> ignored; deq_msg holds 0xA1.
REQ-035 The bench SHALL cover drain from FULL: from the previous scenario, deq_rdy=1 for 2 cycles -> 0xA1 then 0xB2 are dequeued, num_entries goes 2->1->0, and 0xC3 is never seen.
REQ-036 The bench SHALL cover a simultaneous enqueue and dequeue in HALF: holding 0x55, with enq 0x66 and deq_rdy=1 on the same edge -> 0x55 is consumed, deq_msg=0x66, and num_entries stays 1.
REQ-037 The bench SHALL cover reset mid-operation: in FULL holding 0x01 and 0x02, pulse reset for 1 cycle -> deq_val=0, enq_rdy=1, num_entries=0; a subsequent enqueue of 0x03 -> the next deq_msg is 0x03.
REQ-038 The bench SHALL run a random stress test of 1000 cycles with random enq_val/deq_rdy against a reference queue model -> order preserved, no loss, and num_entries never exceeds 2.

Source files
------------

// File: rtl/val_rdy_skid_buf.sv
// val_rdy_skid_buf
//   Two-entry valid/ready buffer. Entry "main" is the head and drives deq_msg;
//   entry "skid" catches a second message while the downstream stalls. Both
//   enq_rdy and deq_val come straight from registered state, so neither
//   side's handshake has a combinational path through this block. This cuts
//   timing between the upstream and downstream stages.
//
//   Handshake: a transfer happens on a posedge where val && rdy are both 1.
//   A sender holds val and msg stable until the transfer happens. A receiver
//   may raise or drop rdy at any time. val never depends on rdy in the same
//   cycle.
//
// Parameters
//   p_nbits      width of the message
// Ports
//   clk          clock; all state changes on posedge
//   reset        synchronous, active-high; empties the buffer
//   enq_val      upstream message valid
//   enq_rdy      buffer can accept a message (state != FULL)
//   enq_msg      upstream message
//   deq_val      buffer presents a message (state != EMPTY)
//   deq_rdy      downstream accepts the message
//   deq_msg      head message (main entry)
//   num_entries  occupancy 0..2. This is also the FSM state encoding, so it
//                doubles as the state debug view.

module val_rdy_skid_buf #(
  parameter int p_nbits = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enq_val,
  output logic               enq_rdy,
  input  logic [p_nbits-1:0] enq_msg,
  output logic               deq_val,
  input  logic               deq_rdy,
  output logic [p_nbits-1:0] deq_msg,
  output logic [1:0]         num_entries
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HALF  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t             state_q;
  logic               enq_rdy_q;
  logic               deq_val_q;
  logic [1:0]         num_q;

  logic [p_nbits-1:0] main_q;
  logic [p_nbits-1:0] main_d;
  logic               main_en;
  logic [p_nbits-1:0] skid_q;
  logic               skid_en;

  logic               enq_fire;
  logic               deq_fire;

  assign enq_rdy     = enq_rdy_q;
  assign deq_val     = deq_val_q;
  assign num_entries = num_q;
  assign deq_msg     = main_q;

  // The handshake outputs are flops, so these fire terms only feed next state.
  assign enq_fire = enq_val && enq_rdy_q;
  assign deq_fire = deq_val_q && deq_rdy;

  // Control FSM. The outputs are registered together with the state, and
  // each transition sets the outputs that belong to the destination state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_EMPTY;
      enq_rdy_q <= 1'b1;
      deq_val_q <= 1'b0;
      num_q     <= 2'd0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (enq_fire) begin
            state_q   <= ST_HALF;
            enq_rdy_q <= 1'b1;
            deq_val_q <= 1'b1;
            num_q     <= 2'd1;
          end
        end
        ST_HALF: begin
          if (enq_fire && !deq_fire) begin
            state_q   <= ST_FULL;
            enq_rdy_q <= 1'b0;
            deq_val_q <= 1'b1;
            num_q     <= 2'd2;
          end else if (!enq_fire && deq_fire) begin
            state_q   <= ST_EMPTY;
            enq_rdy_q <= 1'b1;
            deq_val_q <= 1'b0;
            num_q     <= 2'd0;
          end
        end
        ST_FULL: begin
          // enq_rdy is low here, so only a dequeue can move the state.
          if (deq_fire) begin
            state_q   <= ST_HALF;
            enq_rdy_q <= 1'b1;
            deq_val_q <= 1'b1;
            num_q     <= 2'd1;
          end
        end
        default: begin
          state_q   <= ST_EMPTY;
          enq_rdy_q <= 1'b1;
          deq_val_q <= 1'b0;
          num_q     <= 2'd0;
        end
      endcase
    end
  end

  // Datapath enables. Main loads a new head in three cases: EMPTY receives a
  // message, HALF passes one straight through, or FULL promotes skid after
  // a dequeue. Skid only captures when HALF receives a message while the
  // head stays put.
  always_comb begin
    main_en = 1'b0;
    main_d  = enq_msg;
    skid_en = 1'b0;
    if (!reset) begin
      case (state_q)
        ST_EMPTY: main_en = enq_fire;
        ST_HALF: begin
          main_en = enq_fire && deq_fire;
          skid_en = enq_fire && !deq_fire;
        end
        ST_FULL: begin
          main_en = deq_fire;
          main_d  = skid_q;
        end
        default: main_en = 1'b0;
      endcase
    end
  end

  // Data entries have no reset. Their contents do not matter while they are
  // unoccupied.
  always_ff @(posedge clk) begin
    if (main_en) main_q <= main_d;
  end

  always_ff @(posedge clk) begin
    if (skid_en) skid_q <= enq_msg;
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!reset) begin
      assert (!$isunknown(enq_val)) else $error("enq_val is X");
      assert (!$isunknown(deq_rdy)) else $error("deq_rdy is X");
    end
  end
`endif

endmodule
